clk_div_bank: RTL

Multi-channel programmable clock-enable/divider bank, the parametrised successor of the single fixed-period divider used for slow LED/memory-scan timing in the SoC top. Provides `CHANNELS` independent dividers, each with a runtime-writable period, per-channel enable, a 50% square output and a one-cycle tick strobe. It sits beside the CPU on the `clk` domain and feeds slow-rate logic (LED scanning, memory walk counters, peripheral timebases) without creating new clock domains.

---
 rtl/clk_div_bank.sv | 90 +++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider bank with per-channel enable, 50% output and tick.
// Define CLK_DIV_BANK_SHADOW_EN to defer period writes to each channel's next terminal event.
module clk_div_bank #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 21,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned DEFAULT_PERIOD = 30000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [WIDTH-1:0]    cfg_period,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] per_q, per_d;
  logic [CHANNELS-1:0]            clk_q, clk_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
`ifdef CLK_DIV_BANK_SHADOW_EN
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    clk_d  = clk_q;
    tick_d = '0;
`ifdef CLK_DIV_BANK_SHADOW_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
`endif
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (en[i] && (cnt_q[i] == per_q[i])) begin
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = 1'b1;
        cnt_d[i]  = '0;
`ifdef CLK_DIV_BANK_SHADOW_EN
        if (pend_q[i]) begin
          per_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
`endif
      end else if (en[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // Out-of-range selects never match any channel, so they are dropped here.
      if (cfg_we && (cfg_sel == SEL_W'(i))) begin
`ifdef CLK_DIV_BANK_SHADOW_EN
        // Applied after the terminal update so a coincident write waits one more half-period.
        shadow_d[i] = cfg_period;
        pend_d[i]   = 1'b1;
`else
        per_d[i] = cfg_period;
        cnt_d[i] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= {CHANNELS{WIDTH'(DEFAULT_PERIOD)}};
      clk_q  <= '0;
      tick_q <= '0;
`ifdef CLK_DIV_BANK_SHADOW_EN
      shadow_q <= '0;
      pend_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
`ifdef CLK_DIV_BANK_SHADOW_EN
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule
